// File: rtl/game_state_ctrl_pkg.sv
// Shared game-flow state codes; the video and sprite engines decode the same values.
package game_state_ctrl_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_START    = 3'b000;
   localparam logic [STATE_W-1:0] ST_PLAYING  = 3'b001;
   localparam logic [STATE_W-1:0] ST_PAUSE    = 3'b010;
   localparam logic [STATE_W-1:0] ST_RESET    = 3'b011;
   localparam logic [STATE_W-1:0] ST_GAMEOVER = 3'b100;
   localparam logic [STATE_W-1:0] ST_RESPAWN  = 3'b101;

endpackage

// File: rtl/game_state_ctrl_btn_edge.sv
// Rising-edge detector for a level button; history resets to 1 so a button held
// through reset has to be released before it can act.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= 1'b1;
      else     prev <= btn;
   end

   assign rise = btn & ~prev;

endmodule

// File: rtl/game_state_ctrl.sv
// Multi-player game-flow controller: lives per player, timed respawn, level counter,
// edge-detected start/pause buttons.
module game_state_ctrl
   import game_state_ctrl_pkg::*;
#(
   parameter int NUM_PLAYERS    = 2,
   parameter int LIVES          = 3,
   parameter int LIVES_W        = 2,
   parameter int RESPAWN_CYCLES = 50,
   parameter int LEVEL_W        = 4
) (
   input  logic                           clk,
   input  logic                           resetFSM,
   input  logic                           reset,
   input  logic                           startGame,
   input  logic                           pauseGame,
   input  logic [NUM_PLAYERS-1:0]         dead,
   input  logic                           levelDone,
   output logic [STATE_W-1:0]             stateGame,
   output logic [NUM_PLAYERS*LIVES_W-1:0] lives,
   output logic [NUM_PLAYERS-1:0]         alive,
   output logic [LEVEL_W-1:0]             level,
   output logic                           gameOverP
);

   localparam int CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(RESPAWN_CYCLES - 1);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

   logic                   st_edge, pa_edge;
   logic [STATE_W-1:0]     state, state_n;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic [LEVEL_W-1:0]     level_q, level_n;
   logic                   gop_q, gop_n;
   logic                   reload, dec_en;
   logic [NUM_PLAYERS-1:0] hit, zero_after;

   btn_edge u_start_edge (
      .clk  (clk),
      .rst  (resetFSM),
      .btn  (startGame),
      .rise (st_edge)
   );

   btn_edge u_pause_edge (
      .clk  (clk),
      .rst  (resetFSM),
      .btn  (pauseGame),
      .rise (pa_edge)
   );

   // Deaths only count for players that still have lives left.
   assign hit = dead & alive;

   for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_life
      logic [LIVES_W-1:0] cur, nxt;
      logic               alive_q;

      always_comb begin
         nxt = cur;
         if (reload)                nxt = LIVES_INIT;
         else if (dec_en && hit[i]) nxt = cur - LIVES_W'(1);
      end

      always_ff @(posedge clk or posedge resetFSM) begin
         if (resetFSM) begin
            cur     <= LIVES_INIT;
            alive_q <= 1'b1;
         end else begin
            cur     <= nxt;
            alive_q <= |nxt;
         end
      end

      assign zero_after[i]                 = (cur == '0) | (hit[i] & (cur == LIVES_W'(1)));
      assign lives[i*LIVES_W +: LIVES_W]   = cur;
      assign alive[i]                      = alive_q;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      level_n = level_q;
      gop_n   = 1'b0;
      reload  = 1'b0;
      dec_en  = 1'b0;
      case (state)
         ST_START: begin
            if (reset) begin
               state_n = ST_RESET;
            end else if (st_edge) begin
               state_n = ST_PLAYING;
               reload  = 1'b1;
               level_n = '0;
            end
         end
         ST_PLAYING: begin
            if (reset) begin
               state_n = ST_RESET;
            end else if (|hit) begin
               dec_en = 1'b1;
               if (&zero_after) begin
                  state_n = ST_GAMEOVER;
                  gop_n   = 1'b1;
               end else begin
                  state_n = ST_RESPAWN;
                  cnt_n   = CNT_LOAD;
               end
            end else if (pa_edge) begin
               state_n = ST_PAUSE;
            end else if (levelDone && (level_q != '1)) begin
               level_n = level_q + LEVEL_W'(1);
            end
         end
         ST_PAUSE: begin
            if (reset)                 state_n = ST_RESET;
            else if (pa_edge || st_edge) state_n = ST_PLAYING;
         end
         ST_RESPAWN: begin
            // Loaded with RESPAWN_CYCLES-1 on entry, so the exit at zero gives an exact dwell.
            if (reset)             state_n = ST_RESET;
            else if (cnt == '0)    state_n = ST_PLAYING;
            else                   cnt_n   = cnt - CNT_W'(1);
         end
         ST_GAMEOVER: begin
            if (reset || st_edge) state_n = ST_RESET;
         end
         ST_RESET: begin
            state_n = ST_START;
            reload  = 1'b1;
            level_n = '0;
            cnt_n   = '0;
         end
         default: state_n = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or posedge resetFSM) begin
      if (resetFSM) begin
         state   <= ST_START;
         cnt     <= '0;
         level_q <= '0;
         gop_q   <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         level_q <= level_n;
         gop_q   <= gop_n;
      end
   end

   assign stateGame = state;
   assign level     = level_q;
   assign gameOverP = gop_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with default parameters (2 players, 3 lives, 50-cycle respawn).
module tb_game_state_ctrl;

   logic       clk = 1'b0;
   logic       resetFSM, reset, startGame, pauseGame, levelDone;
   logic [1:0] dead;
   logic [2:0] stateGame;
   logic [3:0] lives;
   logic [1:0] alive;
   logic [3:0] level;
   logic       gameOverP;

   int n_checks = 0;
   int n_errors = 0;

   game_state_ctrl #(
      .NUM_PLAYERS    (2),
      .LIVES          (3),
      .LIVES_W        (2),
      .RESPAWN_CYCLES (50),
      .LEVEL_W        (4)
   ) dut (
      .clk       (clk),
      .resetFSM  (resetFSM),
      .reset     (reset),
      .startGame (startGame),
      .pauseGame (pauseGame),
      .dead      (dead),
      .levelDone (levelDone),
      .stateGame (stateGame),
      .lives     (lives),
      .alive     (alive),
      .level     (level),
      .gameOverP (gameOverP)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entry edge already observed; 49 more cycles in RESPAWN, then PLAYING.
   task automatic run_respawn(input string tag);
      int in_resp = 0;
      for (int i = 0; i < 49; i++) begin
         tick();
         if (stateGame == 3'b101) in_resp++;
      end
      check({tag, "_dwell"}, in_resp, 49);
      tick();
      check({tag, "_exit"}, stateGame, 3'b001);
   endtask

   initial begin
      resetFSM = 1'b1; reset = 1'b0; startGame = 1'b0; pauseGame = 1'b0;
      levelDone = 1'b0; dead = 2'b00;
      tick(); tick();
      check("rst_state", stateGame, 3'b000);
      check("rst_lives", lives, 4'hF);
      check("rst_alive", alive, 2'b11);
      check("rst_level", level, 0);
      check("rst_gop",   gameOverP, 0);
      resetFSM = 1'b0;
      tick();

      // 1: start
      startGame = 1'b1; tick();
      check("t1_state", stateGame, 3'b001);
      check("t1_lives", lives, 4'hF);
      check("t1_level", level, 0);
      startGame = 1'b0;

      // 2: single death, pause held through respawn
      dead = 2'b01; tick();
      dead = 2'b00;
      check("t2_state", stateGame, 3'b101);
      check("t2_lives", lives, 4'hE);
      check("t2_alive", alive, 2'b11);
      pauseGame = 1'b1;
      run_respawn("t2_resp");
      tick();
      check("t2_pause_ign", stateGame, 3'b001);
      pauseGame = 1'b0;

      // 3: simultaneous deaths to game over
      dead = 2'b11; tick(); dead = 2'b00;
      check("t3_lives1", lives, 4'h9);
      run_respawn("t3_r1");
      dead = 2'b11; tick(); dead = 2'b00;
      check("t3_lives2", lives, 4'h4);
      check("t3_alive2", alive, 2'b10);
      check("t3_state2", stateGame, 3'b101);
      run_respawn("t3_r2");
      dead = 2'b11; tick();
      check("t3_go_state", stateGame, 3'b100);
      check("t3_go_lives", lives, 4'h0);
      check("t3_go_alive", alive, 2'b00);
      check("t3_gop_hi", gameOverP, 1);
      tick();
      dead = 2'b00;
      check("t3_gop_lo", gameOverP, 0);
      check("t3_go_hold", stateGame, 3'b100);
      startGame = 1'b1; tick();
      check("t3_reset", stateGame, 3'b011);
      tick();
      check("t3_start", stateGame, 3'b000);
      check("t3_reload", lives, 4'hF);
      startGame = 1'b0; tick();

      // 4: pause held, then resume
      startGame = 1'b1; tick(); startGame = 1'b0;
      check("t4_play", stateGame, 3'b001);
      pauseGame = 1'b1; tick();
      check("t4_pause", stateGame, 3'b010);
      for (int i = 0; i < 4; i++) tick();
      check("t4_pause_held", stateGame, 3'b010);
      pauseGame = 1'b0; tick();
      dead = 2'b11; levelDone = 1'b1; tick(); dead = 2'b00; levelDone = 1'b0;
      check("t4_dead_ign", lives, 4'hF);
      check("t4_lvl_ign", level, 0);
      pauseGame = 1'b1; tick(); pauseGame = 1'b0;
      check("t4_resume", stateGame, 3'b001);

      // 5: level saturation, then game reset
      levelDone = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("t5_level10", level, 10);
      for (int i = 0; i < 10; i++) tick();
      levelDone = 1'b0;
      check("t5_level_sat", level, 15);
      check("t5_state", stateGame, 3'b001);
      reset = 1'b1; tick(); reset = 1'b0;
      check("t5_reset", stateGame, 3'b011);
      tick();
      check("t5_start", stateGame, 3'b000);
      check("t5_level0", level, 0);

      // levelDone coinciding with a death is dropped
      startGame = 1'b1; tick(); startGame = 1'b0;
      levelDone = 1'b1; tick();
      check("t5_lvl1", level, 1);
      dead = 2'b01; tick(); dead = 2'b00; levelDone = 1'b0;
      check("t5_lvl_drop", level, 1);
      check("t5_resp", stateGame, 3'b101);

      // 6: async reset mid-respawn with start held
      startGame = 1'b1;
      tick(); tick();
      resetFSM = 1'b1; #1;
      check("t6_async_state", stateGame, 3'b000);
      check("t6_async_lives", lives, 4'hF);
      check("t6_async_level", level, 0);
      tick();
      resetFSM = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("t6_held", stateGame, 3'b000);
      startGame = 1'b0; tick();
      startGame = 1'b1; tick();
      check("t6_repress", stateGame, 3'b001);
      startGame = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
